// File: rtl/mips_exec_pkg.sv
// Shared constants and types for the MIPS execute-stage ALU and multiply/divide engine.
package mips_exec_pkg;

   // Combinational ALU operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Multiply/divide operation codes
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // Engine sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } md_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: logic ops, add/sub with signed overflow, signed set-less-than.
module alu_core
   import mips_exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero,
   output logic             o_overflow
);

   logic signed [WIDTH-1:0] w_a_s;
   logic signed [WIDTH-1:0] w_b_s;
   logic        [WIDTH-1:0] w_add;
   logic        [WIDTH-1:0] w_sub;
   logic                    w_add_ovf;
   logic                    w_sub_ovf;

   assign w_a_s = i_a;
   assign w_b_s = i_b;
   assign w_add = i_a + i_b;
   assign w_sub = i_a - i_b;

   // Overflow: like-signed add flips sign; unlike-signed subtract lands away from the minuend's sign.
   assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
   assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);

   // Result and overflow select; unknown op codes produce zero.
   always_comb begin
      o_result   = '0;
      o_overflow = 1'b0;
      case (i_op)
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_ADD: begin
            o_result   = w_add;
            o_overflow = w_add_ovf;
         end
         ALU_SUB: begin
            o_result   = w_sub;
            o_overflow = w_sub_ovf;
         end
         ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
         ALU_NOR: o_result = ~(i_a | i_b);
         default: o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_muldiv.sv
// Execute unit: combinational ALU plus an iterative one-bit-per-cycle multiply/divide engine
// that writes HI/LO with a start/busy/done handshake.
module alu_muldiv
   import mips_exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   input  logic [3:0]       ALU_OPERATION,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             OVERFLOW,
   input  logic             MD_START,
   input  logic [1:0]       MD_OP,
   output logic             MD_BUSY,
   output logic             MD_DONE,
   output logic             DIV_BY_ZERO,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH);

   function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] f_cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   alu_core #(.WIDTH(WIDTH)) u_alu_core (
      .i_a        (IN1),
      .i_b        (IN2),
      .i_op       (ALU_OPERATION),
      .o_result   (RESULT),
      .o_zero     (ZERO),
      .o_overflow (OVERFLOW)
   );

   md_state_t        r_state;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_op;
   logic             r_neg_a;
   logic             r_neg_b;
   logic [WIDTH-1:0] r_a_orig;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   // Operand preparation at start: magnitudes for signed ops, signs kept aside.
   logic             w_in_signed;
   logic             w_in_mul;
   logic             w_in_neg_a;
   logic             w_in_neg_b;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;

   assign w_in_signed = (MD_OP == MD_MULT) || (MD_OP == MD_DIV);
   assign w_in_mul    = (MD_OP == MD_MULT) || (MD_OP == MD_MULTU);
   assign w_in_neg_a  = w_in_signed & IN1[WIDTH-1];
   assign w_in_neg_b  = w_in_signed & IN2[WIDTH-1];
   assign w_abs_a     = f_cneg(IN1, w_in_neg_a);
   assign w_abs_b     = f_cneg(IN2, w_in_neg_b);

   // Iteration datapath: shift-add multiply step and restoring shift-subtract divide step.
   logic             w_is_mul;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_borrow;

   assign w_is_mul = (r_op == MD_MULT) || (r_op == MD_MULTU);
   assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
   assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_diff   = w_shift - {1'b0, r_b};
   // The partial remainder is always below the divisor, so a negative difference shows in the top bit.
   assign w_borrow = w_diff[WIDTH];

   // Sign correction of the unsigned magnitudes produced by the iteration.
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_prod_fix = f_cneg2({r_acc_hi, r_acc_lo}, r_neg_a ^ r_neg_b);
   assign w_quo_fix  = f_cneg(r_acc_lo, r_neg_a ^ r_neg_b);
   assign w_rem_fix  = f_cneg(r_acc_hi, r_neg_a);

   // Engine FSM: IDLE accepts a request, CALC iterates WIDTH times, FIX writes HI/LO.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (MD_START) begin
                  r_op     <= MD_OP;
                  r_neg_a  <= w_in_neg_a;
                  r_neg_b  <= w_in_neg_b;
                  r_a_orig <= IN1;
                  r_acc_hi <= '0;
                  r_acc_lo <= w_in_mul ? w_abs_b : w_abs_a;
                  r_b      <= w_in_mul ? w_abs_a : w_abs_b;
                  r_cnt    <= CW'(WIDTH - 1);
                  r_dbz    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               if (w_is_mul) begin
                  r_acc_hi <= w_sum[WIDTH:1];
                  r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
               end else begin
                  r_acc_hi <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                  r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_borrow};
               end
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == '0) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               if (w_is_mul) begin
                  {r_hi, r_lo} <= w_prod_fix;
               end else if (r_b == '0) begin
                  r_lo  <= '1;
                  r_hi  <= r_a_orig;
                  r_dbz <= 1'b1;
               end else begin
                  r_lo <= w_quo_fix;
                  r_hi <= w_rem_fix;
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign MD_BUSY     = r_busy;
   assign MD_DONE     = r_done;
   assign DIV_BY_ZERO = r_dbz;
   assign HI          = r_hi;
   assign LO          = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed and random ALU/multiply/divide traffic.
module tb_alu_muldiv;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] IN1, IN2;
   logic [3:0]  ALU_OPERATION;
   logic [31:0] RESULT;
   logic        ZERO, OVERFLOW;
   logic        MD_START;
   logic [1:0]  MD_OP;
   logic        MD_BUSY, MD_DONE, DIV_BY_ZERO;
   logic [31:0] HI, LO;

   int total = 0;
   int bad   = 0;

   alu_muldiv #(.WIDTH(32)) dut (
      .CLK(CLK), .RESET(RESET), .IN1(IN1), .IN2(IN2), .ALU_OPERATION(ALU_OPERATION),
      .RESULT(RESULT), .ZERO(ZERO), .OVERFLOW(OVERFLOW), .MD_START(MD_START), .MD_OP(MD_OP),
      .MD_BUSY(MD_BUSY), .MD_DONE(MD_DONE), .DIV_BY_ZERO(DIV_BY_ZERO), .HI(HI), .LO(LO)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference multiply/divide computed with 64-bit integer arithmetic.
   task automatic md_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      dbz = 1'b0;
      case (op)
         2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
         2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
         default: begin
            if (b == 32'd0) begin
               lo = 32'hFFFFFFFF; hi = a; dbz = 1'b1;
            end else if (op == 2'b10) begin
               sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0];
            end else begin
               up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0];
            end
         end
      endcase
   endtask

   // Reference ALU computed from the operation definitions.
   task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic ovf);
      longint s;
      ovf = 1'b0;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  begin r = a + b; s = longint'($signed(a)) + longint'($signed(b));
                      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'd6:  begin r = a - b; s = longint'($signed(a)) - longint'($signed(b));
                      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12: r = ~(a | b);
         default: r = 32'd0;
      endcase
   endtask

   task automatic alu_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
      logic [31:0] r;
      logic        ovf;
      ALU_OPERATION = op; IN1 = a; IN2 = b;
      #1;
      alu_model(op, a, b, r, ovf);
      check({tag, "_res"}, RESULT, r);
      check({tag, "_zero"}, ZERO, (r == 32'd0));
      check({tag, "_ovf"}, OVERFLOW, ovf);
   endtask

   // Called at a negedge: present a request, return at the first negedge after the start edge.
   task automatic start_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      MD_START = 1'b1; MD_OP = op; IN1 = a; IN2 = b;
      @(negedge CLK);
      MD_START = 1'b0; IN1 = $urandom; IN2 = $urandom;
      check("busy_c1", MD_BUSY, 1'b1);
      check("dbz_clr", DIV_BY_ZERO, 1'b0);
      check("done_c1", MD_DONE, 1'b0);
   endtask

   // Waits (bounded) for MD_DONE, counting busy cycles; optional stray start at cycle ign_at+1.
   task automatic wait_md(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input int ign_at);
      int   nbusy = 0;
      logic got   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (MD_DONE) begin got = 1'b1; break; end
         if (MD_BUSY) nbusy++;
         if (i == ign_at) begin
            MD_START = 1'b1; MD_OP = 2'b11; IN1 = $urandom; IN2 = 32'd0;
         end else begin
            MD_START = 1'b0;
         end
         @(negedge CLK);
      end
      MD_START = 1'b0;
      check({tag, "_done"}, got, 1'b1);
      check({tag, "_busycyc"}, nbusy, 33);
      check({tag, "_hi"}, HI, ehi);
      check({tag, "_lo"}, LO, elo);
      check({tag, "_dbz"}, DIV_BY_ZERO, edbz);
   endtask

   task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int ign_at);
      logic [31:0] ehi, elo;
      logic        edbz;
      md_model(op, a, b, ehi, elo, edbz);
      start_md(op, a, b);
      wait_md(tag, ehi, elo, edbz, ign_at);
      @(negedge CLK);
      check({tag, "_pulse"}, MD_DONE, 1'b0);
      check({tag, "_hold"}, {HI, LO}, {ehi, elo});
   endtask

   initial begin
      logic [31:0] ehi, elo, a, b;
      logic [1:0]  op;
      logic        edbz;
      int          ndone;

      RESET = 1'b1; MD_START = 1'b0; MD_OP = 2'b00; IN1 = '0; IN2 = '0; ALU_OPERATION = 4'd0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_ctl", {MD_BUSY, MD_DONE, DIV_BY_ZERO}, 3'b000);

      // Directed ALU cases
      alu_check("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001);
      check("add_ovf_val", RESULT, 32'h80000000);
      check("add_ovf_flag", OVERFLOW, 1'b1);
      alu_check("sub_zero", 4'b0110, 32'd5, 32'd5);
      check("sub_zero_flag", ZERO, 1'b1);
      alu_check("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h00000001);
      check("slt_neg_val", RESULT, 32'd1);
      alu_check("op_undef", 4'b0011, 32'h12345678, 32'h0F0F0F0F);
      check("op_undef_val", RESULT, 32'd0);
      alu_check("sub_ovf", 4'b0110, 32'h80000000, 32'h00000001);
      alu_check("nor", 4'b1100, 32'hF0F0_0000, 32'h0000_000F);

      // Random ALU traffic, including undefined op codes
      for (int k = 0; k < 40; k++) begin
         op = 2'b00;
         alu_check("alu_rnd", 4'($urandom_range(0, 15)), $urandom, (k % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      end

      // Directed multiply/divide cases
      @(negedge CLK);
      run_md("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'h00000005, -1);
      check("mult_m3x5_exp", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);
      run_md("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
      check("multu_max_exp", {HI, LO}, 64'hFFFFFFFE_00000001);
      run_md("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h00000002, -1);
      check("div_m7d2_exp", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
      run_md("div_minm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1);
      check("div_minm1_exp", {HI, LO, DIV_BY_ZERO}, {64'h00000000_80000000, 1'b0});
      run_md("divu_z", 2'b11, 32'h00000007, 32'h00000000, -1);
      check("divu_z_exp", {HI, LO, DIV_BY_ZERO}, {64'h00000007_FFFFFFFF, 1'b1});
      run_md("div_sz", 2'b10, 32'hFFFFFFF0, 32'h00000000, -1);

      // Stray start at cycle 10 with new operands must be ignored
      run_md("mult_ign", 2'b00, 32'h00001234, 32'hFFFF0003, 9);

      // Start in the MD_DONE cycle is accepted
      md_model(2'b01, 32'hDEADBEEF, 32'h00010001, ehi, elo, edbz);
      start_md(2'b01, 32'hDEADBEEF, 32'h00010001);
      wait_md("chain1", ehi, elo, edbz, -1);
      md_model(2'b11, 32'hDEADBEEF, 32'h00000010, ehi, elo, edbz);
      start_md(2'b11, 32'hDEADBEEF, 32'h00000010);
      wait_md("chain2", ehi, elo, edbz, -1);
      @(negedge CLK);

      // Reset in the middle of CALC discards the operation
      start_md(2'b00, 32'h00000777, 32'h00000555);
      repeat (14) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      check("midrst_busy", MD_BUSY, 1'b0);
      check("midrst_hilo", {HI, LO}, 64'd0);
      check("midrst_done", MD_DONE, 1'b0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (MD_DONE) ndone++;
      end
      check("midrst_nodone", ndone, 0);
      run_md("mult_3x4", 2'b00, 32'd3, 32'd4, -1);
      check("mult_3x4_exp", {HI, LO}, 64'h00000000_0000000C);

      // Random multiply/divide traffic
      for (int k = 0; k < 14; k++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if (k % 4 == 1) b = b >> $urandom_range(0, 31);
         if (k % 5 == 0) b = 32'd0;
         if (k == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; op = 2'b10; end
         run_md("md_rnd", op, a, b, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
